tinyvga_rx_monitor: RTL

Receive-side monitor for the TinyVGA PMOD byte produced by our VGA renderers. It samples the 8-bit PMOD bus and recovers hsync/vsync timing, locking onto a 640x480 frame structure. Once locked, it emits the decoded pixel stream with coordinates and per-frame statistics (lit-pixel count and optional CRC). It sits in loopback/test harnesses on the same clock as the renderer and checks rendered output without a monitor.

---
 rtl/tinyvga_rx_monitor_if.sv | 24 ++
 rtl/tinyvga_rx_monitor.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/tinyvga_rx_monitor_if.sv
// Bundle for the TinyVGA receive monitor: the sampled PMOD byte in, decoded pixels and
// per-frame statistics out. master drives the PMOD byte; slave is the monitor.
interface tinyvga_rx_monitor_if;
  logic [7:0]  pmod_in;
  logic        pix_valid;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [5:0]  rgb;
  logic        locked;
  logic        frame_done;
  logic [18:0] lit_count;
  logic        sync_err;
  logic [15:0] frame_crc;

  modport master (
    output pmod_in,
    input  pix_valid, pix_x, pix_y, rgb, locked, frame_done, lit_count, sync_err, frame_crc
  );

  modport slave (
    input  pmod_in,
    output pix_valid, pix_x, pix_y, rgb, locked, frame_done, lit_count, sync_err, frame_crc
  );
endinterface

// File: rtl/tinyvga_rx_monitor.sv
// Recovers hsync/vsync timing from the TinyVGA PMOD byte, locks to the frame and reports
// pixels plus per-frame lit count. Define TINYVGA_RX_CRC_EN to add a per-frame CRC-16.
module tinyvga_rx_monitor #(
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_TOTAL  = 800,
  parameter int unsigned V_BACK   = 33,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_TOTAL  = 525
) (
  input logic                 clk,
  input logic                 rst_n,
  tinyvga_rx_monitor_if.slave bus
);

  localparam logic [9:0] HFirst = 10'(H_BACK);
  localparam logic [9:0] HLast  = 10'(H_BACK + H_ACTIVE - 1);
  localparam logic [9:0] VFirst = 10'(V_BACK);
  localparam logic [9:0] VLast  = 10'(V_BACK + V_ACTIVE - 1);
  localparam logic [9:0] HTot   = 10'(H_TOTAL);
  localparam logic [9:0] VTot   = 10'(V_TOTAL);

  typedef enum logic [1:0] {StSearch, StTrack, StLocked} state_e;

  state_e      state_q, state_d;
  logic [7:0]  pmod_q;
  logic        hs_prev_q, vs_prev_q;
  logic [9:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic        first_h_q, first_h_d;
  logic [18:0] acc_q, acc_d, lit_q, lit_d;
  logic        pix_valid_q, pix_valid_d;
  logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [5:0]  rgb_q, rgb_d;
  logic        frame_done_q, sync_err_q;

  logic        h_rise, v_rise, active, err, frame_evt;
  logic [9:0]  hcnt_inc, vcnt_inc, line_cnt;
  logic [5:0]  rgb_cur;

  assign h_rise   = pmod_q[7] & ~hs_prev_q;
  assign v_rise   = pmod_q[3] & ~vs_prev_q;
  assign rgb_cur  = {pmod_q[0], pmod_q[4], pmod_q[1], pmod_q[5], pmod_q[2], pmod_q[6]};
  assign hcnt_inc = hcnt_q + 10'd1;
  assign vcnt_inc = vcnt_q + 10'd1;
  // A coincident hsync edge still closes the last line of the frame being measured.
  assign line_cnt = h_rise ? vcnt_inc : vcnt_q;

  // hcnt_d/vcnt_d are the counts belonging to the byte currently in pmod_q.
  always_comb begin
    hcnt_d = h_rise ? 10'd0 : hcnt_inc;
    vcnt_d = vcnt_q;
    if (v_rise) begin
      vcnt_d = 10'd0;
    end else if (h_rise) begin
      vcnt_d = vcnt_inc;
    end
  end

  assign active = (hcnt_d >= HFirst) && (hcnt_d <= HLast) &&
                  (vcnt_d >= VFirst) && (vcnt_d <= VLast);

  always_comb begin
    err = 1'b0;
    if (state_q != StSearch) begin
      if (!first_h_q && h_rise && (hcnt_inc != HTot))  err = 1'b1;
      if (!first_h_q && !h_rise && (hcnt_inc == HTot)) err = 1'b1;
      if (v_rise && (line_cnt != VTot))                err = 1'b1;
      if (!v_rise && h_rise && (vcnt_inc == VTot))     err = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    frame_evt = 1'b0;
    case (state_q)
      StSearch: begin
        if (v_rise) state_d = StTrack;
      end
      StTrack, StLocked: begin
        if (err) begin
          state_d = StSearch;
        end else if (v_rise) begin
          state_d   = StLocked;
          frame_evt = 1'b1;
        end
      end
      default: state_d = StSearch;
    endcase
  end

  // The line in progress when TRACK is entered has unknown length, so skip its check.
  always_comb begin
    first_h_d = first_h_q;
    if (state_q == StSearch && v_rise) begin
      first_h_d = 1'b1;
    end else if (h_rise) begin
      first_h_d = 1'b0;
    end
  end

  always_comb begin
    acc_d = acc_q;
    lit_d = lit_q;
    if (err || v_rise) begin
      acc_d = '0;
    end else if (active && (rgb_cur != 6'd0)) begin
      acc_d = acc_q + 19'd1;
    end
    if (frame_evt) lit_d = acc_q;
  end

  always_comb begin
    pix_valid_d = active && (state_q == StLocked) && !err;
    pix_x_d     = pix_valid_d ? (hcnt_d - HFirst) : 10'd0;
    pix_y_d     = pix_valid_d ? (vcnt_d - VFirst) : 10'd0;
    rgb_d       = pix_valid_d ? rgb_cur : 6'd0;
  end

  // Sync bits reset to their idle (deasserted) level so release does not fake an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pmod_q       <= 8'h88;
      hs_prev_q    <= 1'b1;
      vs_prev_q    <= 1'b1;
      state_q      <= StSearch;
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      first_h_q    <= 1'b0;
      acc_q        <= '0;
      lit_q        <= '0;
      pix_valid_q  <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      rgb_q        <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      pmod_q       <= bus.pmod_in;
      hs_prev_q    <= pmod_q[7];
      vs_prev_q    <= pmod_q[3];
      state_q      <= state_d;
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      first_h_q    <= first_h_d;
      acc_q        <= acc_d;
      lit_q        <= lit_d;
      pix_valid_q  <= pix_valid_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      rgb_q        <= rgb_d;
      frame_done_q <= frame_evt;
      sync_err_q   <= err;
    end
  end

`ifdef TINYVGA_RX_CRC_EN
  logic [15:0] crc_q, crc_d, fcrc_q, fcrc_d;

  // CRC-16-CCITT, six bits per pixel, MSB first.
  function automatic logic [15:0] crc_step6(input logic [15:0] crc, input logic [5:0] d);
    logic [15:0] c;
    c = crc;
    for (int i = 5; i >= 0; i--) begin
      if (c[15] ^ d[i]) begin
        c = {c[14:0], 1'b0} ^ 16'h1021;
      end else begin
        c = {c[14:0], 1'b0};
      end
    end
    return c;
  endfunction

  always_comb begin
    crc_d  = crc_q;
    fcrc_d = fcrc_q;
    if (err || v_rise) begin
      crc_d = 16'hFFFF;
    end else if (active) begin
      crc_d = crc_step6(crc_q, rgb_cur);
    end
    if (frame_evt) fcrc_d = crc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q  <= 16'hFFFF;
      fcrc_q <= '0;
    end else begin
      crc_q  <= crc_d;
      fcrc_q <= fcrc_d;
    end
  end

  assign bus.frame_crc = fcrc_q;
`else
  assign bus.frame_crc = 16'h0000;
`endif

  assign bus.pix_valid  = pix_valid_q;
  assign bus.pix_x      = pix_x_q;
  assign bus.pix_y      = pix_y_q;
  assign bus.rgb        = rgb_q;
  assign bus.locked     = (state_q == StLocked);
  assign bus.frame_done = frame_done_q;
  assign bus.lit_count  = lit_q;
  assign bus.sync_err   = sync_err_q;

endmodule
